// File: rtl/cv32e40s_pkg.sv
// Shared types and constants for the PC hardening checker.
package cv32e40s_pkg;

  // Address-check FSM states
  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    TGT_WAIT = 2'd1,
    SKIP     = 2'd2,
    SEQ      = 2'd3
  } pc_chk_state_e;

  // Bit positions inside err_cause_o
  localparam int PC_ERR_ADDR    = 0;
  localparam int PC_ERR_TAKEN   = 1;
  localparam int PC_ERR_UNTAKEN = 2;

  // PC that must follow the instruction in ID; dummies do not advance the PC
  function automatic logic [31:0] pc_seq_next(logic [31:0] pc, logic compressed, logic dummy);
    return pc + (dummy ? 32'd0 : (compressed ? 32'd2 : 32'd4));
  endfunction

endpackage

// File: rtl/cv32e40s_pc_check_cf_chan.sv
// One control-flow decision channel: remembers that a taken PC change was
// issued and flags taken/untaken mismatches against the recomputed decision.
module cv32e40s_pc_check_cf_chan (
  input  logic clk,
  input  logic rst_n,
  input  logic set_i,
  input  logic done_i,
  input  logic kill_i,
  input  logic raw_i,
  input  logic vld_i,
  input  logic last_i,
  input  logic dec_i,
  output logic taken_err_o,
  output logic untaken_err_o
);

  logic taken_q, taken_d;

  // Clear wins over set so a kill in the same cycle never leaves a stale flag
  always_comb begin
    taken_d = taken_q;
    if (done_i || kill_i) taken_d = 1'b0;
    else if (set_i)       taken_d = 1'b1;
  end

  // Taken flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) taken_q <= 1'b0;
    else        taken_q <= taken_d;
  end

  assign taken_err_o   = taken_q & ~(raw_i & dec_i);
  assign untaken_err_o = ~taken_q & raw_i & vld_i & last_i & dec_i;

endmodule

// File: rtl/cv32e40s_pc_check_multi.sv
// PC hardening checker: latches the expected target on pc_set, compares it for
// as long as the target sits in IF, checks sequential steps, cross-checks
// per-channel branch/jump decisions, and counts errors towards a sticky alert.
module cv32e40s_pc_check_multi
  import cv32e40s_pkg::*;
#(
  parameter int N_TGT     = 12,
  parameter int TGT_SEL_W = $clog2(N_TGT),
  parameter int N_CF      = 2,
  parameter int CNT_W     = 4,
  parameter int ALERT_THR = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       if_valid_i,
  input  logic                       id_ready_i,
  input  logic                       prefetch_is_ptr_i,
  input  logic [31:0]                pc_if_i,
  input  logic [31:0]                id_pc_i,
  input  logic                       id_compressed_i,
  input  logic                       id_dummy_i,
  input  logic                       pc_set_i,
  input  logic [TGT_SEL_W-1:0]       pc_sel_i,
  input  logic [N_TGT-1:0][31:0]     tgt_addr_i,
  input  logic [N_TGT-1:0]           tgt_chk_en_i,
  input  logic [N_CF-1:0]            cf_set_i,
  input  logic [N_CF-1:0]            cf_done_i,
  input  logic [N_CF-1:0]            cf_kill_i,
  input  logic [N_CF-1:0]            cf_raw_i,
  input  logic [N_CF-1:0]            cf_vld_i,
  input  logic [N_CF-1:0]            cf_last_i,
  input  logic [N_CF-1:0]            cf_dec_i,
  output logic                       pc_err_o,
  output logic [2:0]                 err_cause_o,
  output logic [CNT_W-1:0]           err_cnt_o,
  output logic                       alert_major_o
);

  localparam int              N_SEL = 2**TGT_SEL_W;
  localparam logic [CNT_W-1:0] THR  = CNT_W'(ALERT_THR);

  pc_chk_state_e          state_q, state_d;
  logic [31:0]            exp_q, exp_d;
  logic                   seq_q, seq_d;
  logic                   pc_err_q, pc_err_d;
  logic [2:0]             cause_q, cause_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   alert_q, alert_d;

  logic [N_SEL-1:0]       chk_en_pad;
  logic [N_SEL-1:0][31:0] tgt_pad;
  logic [31:0]            seq_pc;
  logic                   hs;
  logic                   addr_err;
  logic [N_CF-1:0]        taken_err, untaken_err;

  // Pad the target tables to the full select range; unused selects read as unchecked
  always_comb begin
    chk_en_pad             = '0;
    tgt_pad                = '0;
    chk_en_pad[N_TGT-1:0]  = tgt_chk_en_i;
    tgt_pad[N_TGT-1:0]     = tgt_addr_i;
  end

  assign hs     = if_valid_i & id_ready_i;
  assign seq_pc = pc_seq_next(id_pc_i, id_compressed_i, id_dummy_i);

  // Address compare against the current (pre-pc_set) state
  always_comb begin
    addr_err = 1'b0;
    case (state_q)
      TGT_WAIT: addr_err = if_valid_i && (pc_if_i != exp_q);
      SEQ:      addr_err = seq_q && (pc_if_i != seq_pc);
      default:  addr_err = 1'b0;
    endcase
  end

  // FSM next state and expected-target latch; pc_set overrides everything
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    seq_d   = hs && !prefetch_is_ptr_i;
    if (pc_set_i) begin
      if (chk_en_pad[pc_sel_i]) begin
        exp_d   = tgt_pad[pc_sel_i] & 32'hFFFF_FFFE;
        state_d = TGT_WAIT;
      end else begin
        state_d = SKIP;
      end
    end else begin
      case (state_q)
        TGT_WAIT, SKIP: if (hs) state_d = SEQ;
        default:        state_d = state_q;
      endcase
    end
  end

  // Decision channels
  for (genvar c = 0; c < N_CF; c++) begin : g_cf
    cv32e40s_pc_check_cf_chan u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .set_i         (cf_set_i[c]),
      .done_i        (cf_done_i[c]),
      .kill_i        (cf_kill_i[c]),
      .raw_i         (cf_raw_i[c]),
      .vld_i         (cf_vld_i[c]),
      .last_i        (cf_last_i[c]),
      .dec_i         (cf_dec_i[c]),
      .taken_err_o   (taken_err[c]),
      .untaken_err_o (untaken_err[c])
    );
  end

  // Error cause, saturating count and sticky alert
  always_comb begin
    cause_d                 = '0;
    cause_d[PC_ERR_ADDR]    = addr_err;
    cause_d[PC_ERR_TAKEN]   = (|taken_err)   && (state_q != DISABLED);
    cause_d[PC_ERR_UNTAKEN] = (|untaken_err) && (state_q != DISABLED);
    pc_err_d                = |cause_d;
    cnt_d                   = cnt_q;
    if (pc_err_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    alert_d                 = alert_q | (cnt_d >= THR);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DISABLED;
      exp_q    <= '0;
      seq_q    <= 1'b0;
      pc_err_q <= 1'b0;
      cause_q  <= '0;
      cnt_q    <= '0;
      alert_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      seq_q    <= seq_d;
      pc_err_q <= pc_err_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
      alert_q  <= alert_d;
    end
  end

  assign pc_err_o      = pc_err_q;
  assign err_cause_o   = cause_q;
  assign err_cnt_o     = cnt_q;
  assign alert_major_o = alert_q;

endmodule

// File: tb/tb_cv32e40s_pc_check_multi.sv
// Bench for the PC hardening checker: directed scenarios plus randomized
// traffic, all scored against a behavioural model of the checking rules.
module tb_cv32e40s_pc_check_multi;

  localparam int N_TGT     = 12;
  localparam int TGT_SEL_W = 4;
  localparam int N_CF      = 2;
  localparam int CNT_W     = 4;
  localparam int ALERT_THR = 3;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   if_valid, id_ready, ptr;
  logic [31:0]            pc_if, id_pc;
  logic                   id_comp, id_dummy;
  logic                   pc_set;
  logic [TGT_SEL_W-1:0]   pc_sel;
  logic [N_TGT-1:0][31:0] tgt_addr;
  logic [N_TGT-1:0]       tgt_chk_en;
  logic [N_CF-1:0]        cf_set, cf_done, cf_kill, cf_raw, cf_vld, cf_last, cf_dec;
  logic                   pc_err;
  logic [2:0]             err_cause;
  logic [CNT_W-1:0]       err_cnt;
  logic                   alert;

  always #5 clk = ~clk;

  cv32e40s_pc_check_multi #(
    .N_TGT(N_TGT), .TGT_SEL_W(TGT_SEL_W), .N_CF(N_CF), .CNT_W(CNT_W), .ALERT_THR(ALERT_THR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid_i(if_valid), .id_ready_i(id_ready), .prefetch_is_ptr_i(ptr),
    .pc_if_i(pc_if), .id_pc_i(id_pc), .id_compressed_i(id_comp), .id_dummy_i(id_dummy),
    .pc_set_i(pc_set), .pc_sel_i(pc_sel), .tgt_addr_i(tgt_addr), .tgt_chk_en_i(tgt_chk_en),
    .cf_set_i(cf_set), .cf_done_i(cf_done), .cf_kill_i(cf_kill), .cf_raw_i(cf_raw),
    .cf_vld_i(cf_vld), .cf_last_i(cf_last), .cf_dec_i(cf_dec),
    .pc_err_o(pc_err), .err_cause_o(err_cause), .err_cnt_o(err_cnt), .alert_major_o(alert)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: armed = a pc_set has been seen; pend = target not yet
  // accepted by ID (checked or not); otherwise sequential checking.
  bit              m_armed, m_pend, m_pend_chk, m_prev_hs, m_err, m_alert;
  logic [31:0]     m_tgt;
  bit [N_CF-1:0]   m_taken;
  bit [2:0]        m_cause;
  int              m_cnt;

  function automatic logic [31:0] next_pc(logic [31:0] pc, logic c, logic d);
    logic [31:0] s;
    s = pc + (d ? 0 : (c ? 2 : 4));
    return s;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_pend = 0; m_pend_chk = 0; m_prev_hs = 0;
    m_taken = '0; m_err = 0; m_cause = '0; m_cnt = 0; m_alert = 0; m_tgt = '0;
  endtask

  task automatic model_eval();
    bit a, t, u;
    a = 0; t = 0; u = 0;
    if (m_armed) begin
      if (m_pend) a = m_pend_chk && if_valid && (pc_if != m_tgt);
      else        a = m_prev_hs && (pc_if != next_pc(id_pc, id_comp, id_dummy));
      for (int c = 0; c < N_CF; c++) begin
        if (m_taken[c] && !(cf_raw[c] && cf_dec[c])) t = 1;
        if (!m_taken[c] && cf_raw[c] && cf_vld[c] && cf_last[c] && cf_dec[c]) u = 1;
      end
    end
    if (pc_set) begin
      m_armed    = 1;
      m_pend     = 1;
      m_pend_chk = (int'(pc_sel) < N_TGT) && tgt_chk_en[pc_sel];
      if (m_pend_chk) m_tgt = {tgt_addr[pc_sel][31:1], 1'b0};
    end else if (m_armed && m_pend && if_valid && id_ready) begin
      m_pend = 0;
    end
    m_prev_hs = if_valid && id_ready && !ptr;
    for (int c = 0; c < N_CF; c++) begin
      if (cf_done[c] || cf_kill[c]) m_taken[c] = 0;
      else if (cf_set[c])           m_taken[c] = 1;
    end
    m_cause = {u, t, a};
    m_err   = a | t | u;
    if (m_err && m_cnt < CNT_MAX) m_cnt++;
    if (m_cnt >= ALERT_THR) m_alert = 1;
  endtask

  // One clock: model sees the applied inputs, DUT registers them, outputs compared
  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
    chk("err",   32'(pc_err),    32'(m_err));
    chk("cause", 32'(err_cause), 32'(m_cause));
    chk("cnt",   32'(err_cnt),   32'(m_cnt));
    chk("alert", 32'(alert),     32'(m_alert));
  endtask

  task automatic idle_in();
    if_valid = 0; id_ready = 0; ptr = 0; pc_set = 0;
    cf_set = '0; cf_done = '0; cf_kill = '0; cf_raw = '0; cf_vld = '0; cf_last = '0; cf_dec = '0;
    pc_if = next_pc(id_pc, id_comp, id_dummy);
  endtask

  task automatic idle();
    idle_in();
    tick();
  endtask

  // Reset asserted mid-cycle (away from the edge); outputs must clear at once
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_err",   32'(pc_err),    32'd0);
    chk("rst_cause", 32'(err_cause), 32'd0);
    chk("rst_cnt",   32'(err_cnt),   32'd0);
    chk("rst_alert", 32'(alert),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_inputs();
    logic [31:0] good;
    pc_set     = ($urandom_range(7) == 0);
    pc_sel     = TGT_SEL_W'($urandom_range(15));
    tgt_chk_en = N_TGT'($urandom | $urandom);
    for (int i = 0; i < N_TGT; i++) tgt_addr[i] = $urandom;
    if_valid   = ($urandom_range(3) != 0);
    id_ready   = ($urandom_range(3) != 0);
    ptr        = ($urandom_range(7) == 0);
    id_pc      = ($urandom_range(15) == 0) ? 32'hFFFF_FFFE : $urandom;
    id_comp    = 1'($urandom_range(1));
    id_dummy   = ($urandom_range(7) == 0);
    good       = (m_pend && m_pend_chk) ? m_tgt : next_pc(id_pc, id_comp, id_dummy);
    pc_if      = ($urandom_range(15) == 0) ? $urandom : good;
    cf_set     = N_CF'($urandom & $urandom & $urandom);
    cf_done    = N_CF'($urandom & $urandom & $urandom);
    cf_kill    = N_CF'($urandom & $urandom & $urandom & $urandom);
    cf_raw     = N_CF'($urandom);
    cf_vld     = N_CF'($urandom | $urandom);
    cf_last    = N_CF'($urandom | $urandom);
    cf_dec     = N_CF'($urandom);
  endtask

  initial begin
    id_pc = '0; id_comp = 0; id_dummy = 0; pc_sel = '0;
    tgt_chk_en = '1;
    for (int i = 0; i < N_TGT; i++) tgt_addr[i] = $urandom;
    idle_in();
    async_reset();

    // Checked target then clean sequential steps (4-byte and compressed)
    pc_set = 1; pc_sel = 0; tgt_addr[0] = 32'h0000_0080; tick(); pc_set = 0;
    if_valid = 1; id_ready = 1; pc_if = 32'h80; tick();
    id_pc = 32'h80; id_comp = 0; pc_if = 32'h84; tick();
    id_pc = 32'h84; id_comp = 1; pc_if = 32'h86; if_valid = 0; id_ready = 0; tick();
    chk("t1_noerr", 32'(pc_err), 32'd0);

    // PC changes under an IF stall while the target is pending
    idle();
    pc_set = 1; pc_sel = 1; tgt_addr[1] = 32'h0000_1000; tick(); pc_set = 0;
    if_valid = 1; id_ready = 0; pc_if = 32'h1000; tick();
    pc_if = 32'h1004; tick();
    chk("t2_err",   32'(pc_err),    32'd1);
    chk("t2_cause", 32'(err_cause), 32'b001);
    chk("t2_cnt",   32'(err_cnt),   32'd1);
    pc_if = 32'h1000; tick();
    id_ready = 1; tick();
    id_pc = 32'h1000; id_comp = 0;

    // Unchecked target, then a wrong first sequential step
    idle();
    pc_set = 1; pc_sel = 2; tgt_chk_en[2] = 0; tick(); pc_set = 0; tgt_chk_en[2] = 1;
    if_valid = 1; id_ready = 1; pc_if = 32'hDEAD_0000; tick();
    chk("t3_skip", 32'(pc_err), 32'd0);
    if_valid = 0; id_ready = 0; id_pc = 32'hDEAD_0000; id_comp = 0; pc_if = 32'hDEAD_0008; tick();
    chk("t3_seq_cause", 32'(err_cause), 32'b001);
    chk("t3_alert",     32'(alert),     32'd0);

    // Decision channel 1: taken mismatch, clean clear, untaken mismatch
    idle();
    cf_set[1] = 1; tick(); cf_set[1] = 0;
    cf_raw[1] = 1; cf_dec[1] = 0; tick();
    chk("t4_taken", 32'(err_cause), 32'b010);
    chk("t4_cnt3",  32'(err_cnt),   32'd3);
    chk("t4_alert", 32'(alert),     32'd1);
    cf_done[1] = 1; cf_dec[1] = 1; tick();
    chk("t4_done", 32'(pc_err), 32'd0);
    cf_done[1] = 0; cf_vld[1] = 1; cf_last[1] = 1; tick();
    chk("t4_untaken", 32'(err_cause), 32'b100);
    repeat (20) tick();
    chk("t5_sat",   32'(err_cnt), 32'd15);
    chk("t5_alert", 32'(alert),   32'd1);

    // Back-to-back pc_set: only the last target counts (bit 0 dropped)
    idle();
    pc_set = 1; pc_sel = 3; tgt_addr[3] = 32'h200; tick();
    pc_sel = 4; tgt_addr[4] = 32'h301; tick(); pc_set = 0;
    if_valid = 1; id_ready = 1; pc_if = 32'h300; tick();
    chk("b2b_noerr", 32'(pc_err), 32'd0);

    // Sequential wrap past the top of the address space
    if_valid = 0; id_ready = 0; id_pc = 32'hFFFF_FFFC; id_comp = 0; id_dummy = 0; pc_if = 32'h0; tick();
    chk("wrap_noerr", 32'(pc_err), 32'd0);

    // Reset mid-operation with an error condition present; then masked while disabled
    cf_raw[0] = 1; cf_vld[0] = 1; cf_last[0] = 1; cf_dec[0] = 1;
    async_reset();
    tick();
    chk("dis_mask", 32'(pc_err), 32'd0);

    // Randomized traffic in short blocks separated by resets
    for (int b = 0; b < 10; b++) begin
      idle_in();
      async_reset();
      repeat (60) begin
        rand_inputs();
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
